// File: rtl/data_mem_ctrl_pkg.sv
// rtl/data_mem_ctrl_pkg.sv - shared state encoding, width codes and lane masks for data_mem_ctrl
package data_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ1 = 2'd1,
    ST_REQ2 = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;
  localparam logic [1:0] W_RSVD = 2'b11;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  // Lane mask of an access that starts at lane 0.
  function automatic logic [3:0] size_mask(input logic [1:0] width);
    case (width)
      W_BYTE:  size_mask = MASK_BYTE;
      W_HALF:  size_mask = MASK_HALF;
      default: size_mask = MASK_WORD;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_align.sv
// rtl/data_mem_ctrl_align.sv - load lane extraction and sign/zero extension
module mem_load_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [55:0] lanes,
  input  logic [1:0]  offset,
  input  logic [1:0]  width,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [31:0] word;

  // Pick the bytes starting at the access offset, then extend to 32 bits.
  always_comb begin
    word = lanes[{offset, 3'b000} +: 32];
    case (width)
      W_BYTE:  data = {{24{sign_ext & word[7]}}, word[7:0]};
      W_HALF:  data = {{16{sign_ext & word[15]}}, word[15:0]};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - MEM-stage load/store controller with split access and bus timeout
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_width,
  input  logic        mem_sign_extend,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

  state_e      state;
  logic [1:0]  cap_off;
  logic [1:0]  cap_width;
  logic        cap_sign;
  logic        cap_we;
  logic [31:0] cap_wdata;
  logic [7:0]  wait_cnt;
  logic [55:0] rd_lanes;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_ok;
  logic        req_bad;
  logic        idle_open;
  logic        timeout;
  logic [1:0]  src_off;
  logic [1:0]  src_width;
  logic [31:0] src_wdata;
  logic [7:0]  plan_mask;
  logic [63:0] plan_data;
  logic        split;
  logic [31:0] align_data;

  // The cycle after a timeout abort still presents the faulted request; it is not re-accepted.
  assign idle_open = (state == ST_IDLE) && !err_q;
  assign req_ok    = (mem_read ^ mem_write) && (mem_width != W_RSVD);
  assign req_bad   = (mem_read | mem_write) && !req_ok;
  assign timeout   = (wait_cnt + 8'd1) == TO_LIM;

  // Lane plan: from live inputs while capturing, from the captured copy afterwards.
  assign src_off   = (state == ST_IDLE) ? addr[1:0] : cap_off;
  assign src_width = (state == ST_IDLE) ? mem_width : cap_width;
  assign src_wdata = (state == ST_IDLE) ? wdata     : cap_wdata;
  assign plan_mask = {4'b0000, size_mask(src_width)} << src_off;
  assign plan_data = {32'd0, src_wdata} << {src_off, 3'b000};
  assign split     = |plan_mask[7:4];

  assign stall = (idle_open && req_ok) || (state == ST_REQ1) || (state == ST_REQ2);
  assign err   = err_q || (idle_open && req_bad);
  assign rdata = (state == ST_DONE) ? align_data : rdata_q;

  mem_load_align u_align (
    .lanes    (rd_lanes),
    .offset   (cap_off),
    .width    (cap_width),
    .sign_ext (cap_sign),
    .data     (align_data)
  );

  // Access FSM with registered bus outputs, wait counter and load assembly buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cap_off   <= 2'b00;
      cap_width <= W_BYTE;
      cap_sign  <= 1'b0;
      cap_we    <= 1'b0;
      cap_wdata <= 32'd0;
      wait_cnt  <= 8'd0;
      rd_lanes  <= 56'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      done      <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 30'd0;
      bus_wstrb <= 4'b0000;
      bus_wdata <= 32'd0;
    end else begin
      err_q <= 1'b0;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (idle_open && req_ok) begin
            cap_off   <= addr[1:0];
            cap_width <= mem_width;
            cap_sign  <= mem_sign_extend;
            cap_we    <= mem_write;
            cap_wdata <= wdata;
            wait_cnt  <= 8'd0;
            rd_lanes  <= 56'd0;
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= addr[31:2];
            bus_wstrb <= mem_write ? plan_mask[3:0] : 4'b0000;
            bus_wdata <= plan_data[31:0];
            state     <= ST_REQ1;
          end
        end
        ST_REQ1: begin
          if (bus_ack) begin
            if (!cap_we) rd_lanes[31:0] <= bus_rdata;
            wait_cnt <= 8'd0;
            if (split) begin
              bus_addr  <= bus_addr + 30'd1;
              bus_wstrb <= cap_we ? plan_mask[7:4] : 4'b0000;
              bus_wdata <= plan_data[63:32];
              state     <= ST_REQ2;
            end else begin
              bus_req   <= 1'b0;
              bus_we    <= 1'b0;
              bus_wstrb <= 4'b0000;
              done      <= 1'b1;
              state     <= ST_DONE;
            end
          end else if (timeout) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_wstrb <= 4'b0000;
            err_q     <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_REQ2: begin
          if (bus_ack) begin
            if (!cap_we) rd_lanes[55:32] <= bus_rdata[23:0];
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_wstrb <= 4'b0000;
            done      <= 1'b1;
            state     <= ST_DONE;
          end else if (timeout) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_wstrb <= 4'b0000;
            err_q     <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          rdata_q <= align_data;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  mem_width = 2'b00;
  logic        mem_sign_extend = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        stall;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  data_mem_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_width(mem_width), .mem_sign_extend(mem_sign_extend), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .done(done), .err(err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int done_cnt = 0;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bench memory: each word either a forced value or a hash of its word address.
  bit          fw_en = 1'b0;
  logic [31:0] fw = 32'd0;

  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    logic [31:0] h;
    h = {2'b00, wa} * 32'h9E3779B1 ^ 32'h5A5AC3C3;
    return fw_en ? fw : h;
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  logic [29:0] obs_addr [2];
  logic [3:0]  obs_strb [2];
  logic [31:0] obs_wdata[2];
  int          n_obs;

  task automatic idle_inputs();
    mem_read = 1'b0; mem_write = 1'b0; mem_width = 2'b00; mem_sign_extend = 1'b0;
    addr = $urandom; wdata = $urandom;
  endtask

  // One full access: byte-level reference model, bus responder and output checks.
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] w, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd, input int dly);
    int          size, ntx, txi, wc, stall_cnt, off;
    bit          fin, to_exp;
    logic [29:0] ew[2];
    logic [3:0]  es[2];
    logic [31:0] ed[2];
    logic [31:0] exp_rd, ba;
    logic [7:0]  byt;

    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_width = w; mem_sign_extend = sg;
    addr = a; wdata = wd; bus_ack = 1'b0;
    n_obs = 0;
    if ((rd && wr) || ((rd || wr) && w == 2'b11)) begin
      #1;
      check("illegal_err", 32'(err), 32'd1);
      check("illegal_stall", 32'(stall), 32'd0);
      check("illegal_busreq", 32'(bus_req), 32'd0);
      @(negedge clk);
      idle_inputs();
      #1;
      check("illegal_err_clear", 32'(err), 32'd0);
      check("illegal_busreq_after", 32'(bus_req), 32'd0);
      return;
    end

    size = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    to_exp = (dly >= TO);
    ntx = 0;
    exp_rd = 32'd0;
    for (int i = 0; i < size; i++) begin
      ba = a + 32'(i);
      off = int'(ba[1:0]);
      if (ntx == 0 || ew[ntx-1] != ba[31:2]) begin
        ew[ntx] = ba[31:2]; es[ntx] = 4'b0000; ed[ntx] = 32'd0; ntx++;
      end
      if (wr) begin
        es[ntx-1][off] = 1'b1;
        ed[ntx-1][8*off +: 8] = wd[8*i +: 8];
      end
      byt = 8'(mem_word(ba[31:2]) >> (8 * off));
      exp_rd[8*i +: 8] = byt;
    end
    if (wr) exp_rd = 32'd0;
    else if (sg && size == 1) exp_rd = {{24{exp_rd[7]}}, exp_rd[7:0]};
    else if (sg && size == 2) exp_rd = {{16{exp_rd[15]}}, exp_rd[15:0]};

    #1;
    check("req_cycle_stall", 32'(stall), 32'd1);
    stall_cnt = 1; txi = 0; wc = 0; fin = 1'b0;

    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      @(negedge clk);
      bus_ack = 1'b0;
      bus_rdata = $urandom;
      // inputs may wander while stalled; the captured copy must be used
      addr = $urandom; wdata = $urandom; mem_width = 2'($urandom_range(0, 2));
      mem_sign_extend = 1'($urandom);
      #1;
      if (bus_req === 1'b1) begin
        stall_cnt++;
        check("req_stall", 32'(stall), 32'd1);
        if (txi < ntx) begin
          check("bus_addr", 32'(bus_addr), 32'(ew[txi]));
          check("bus_we", 32'(bus_we), 32'(wr));
          check("bus_wstrb", 32'(bus_wstrb), wr ? 32'(es[txi]) : 32'd0);
          if (wr) check("bus_wdata", bus_wdata & lane_bits(es[txi]), ed[txi]);
        end else begin
          check("extra_bus_req", 32'(bus_req), 32'd0);
        end
        if (wc == 0 && n_obs < 2) begin
          obs_addr[n_obs] = bus_addr; obs_strb[n_obs] = bus_wstrb; obs_wdata[n_obs] = bus_wdata;
          n_obs++;
        end
        if (wc == dly) begin
          bus_ack = 1'b1;
          bus_rdata = mem_word(bus_addr);
          txi++; wc = 0;
        end else begin
          wc++;
        end
      end else if (done === 1'b1) begin
        fin = 1'b1;
        check("done_expected", 32'(to_exp), 32'd0);
        check("done_rdata", rdata, exp_rd);
        check("done_stall", 32'(stall), 32'd0);
        check("done_err", 32'(err), 32'd0);
        check("tx_count", 32'(txi), 32'(ntx));
        check("stall_cycles", 32'(stall_cnt), 32'(1 + ntx * (dly + 1)));
        idle_inputs();
        @(negedge clk); #1;
        check("rdata_hold", rdata, exp_rd);
        check("done_clear", 32'(done), 32'd0);
        check("busreq_after_done", 32'(bus_req), 32'd0);
      end else if (err === 1'b1) begin
        fin = 1'b1;
        check("timeout_expected", 32'(to_exp), 32'd1);
        check("timeout_wait", 32'(wc), 32'(TO));
        check("timeout_stall", 32'(stall), 32'd0);
        check("timeout_done", 32'(done), 32'd0);
        idle_inputs();
        @(negedge clk); #1;
        check("timeout_err_clear", 32'(err), 32'd0);
        check("timeout_busreq", 32'(bus_req), 32'd0);
        check("timeout_no_done", 32'(done), 32'd0);
      end else begin
        fin = 1'b1;
        check("bus_req_missing", 32'(bus_req), 32'd1);
        idle_inputs();
      end
    end
    if (!fin) begin
      check("access_bound", 32'd0, 32'd1);
      idle_inputs();
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  w;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    int          dly;
    bit          fwe;
    logic [31:0] fwv;
    bit          chk;
    logic [31:0] exp_rd;
    logic [29:0] exp_a1;
  } vec_t;

  vec_t tbl[11];
  int   dc;

  initial begin
    tbl[0]  = '{1, 0, 2'b10, 0, 32'h00000100, 32'h0,        0, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 30'h40};
    tbl[1]  = '{1, 0, 2'b00, 1, 32'h00000103, 32'h0,        0, 1, 32'h80123456, 1, 32'hFFFFFF80, 30'h40};
    tbl[2]  = '{1, 0, 2'b00, 0, 32'h00000103, 32'h0,        0, 1, 32'h80123456, 1, 32'h00000080, 30'h40};
    tbl[3]  = '{1, 0, 2'b10, 0, 32'hFFFFFFFF, 32'h0,        1, 1, 32'h44332211, 1, 32'h33221144, 30'h3FFFFFFF};
    tbl[4]  = '{1, 0, 2'b01, 1, 32'h00000102, 32'h0,        0, 1, 32'h80017777, 1, 32'hFFFF8001, 30'h40};
    tbl[5]  = '{1, 0, 2'b01, 0, 32'h00000003, 32'h0,        2, 1, 32'hAABBCCDD, 1, 32'h0000DDAA, 30'h0};
    tbl[6]  = '{0, 1, 2'b10, 0, 32'h000001FE, 32'h11223344, 0, 0, 32'h0,        1, 32'h0,        30'h7F};
    tbl[7]  = '{0, 1, 2'b00, 0, 32'h00000005, 32'h000000A5, 2, 0, 32'h0,        1, 32'h0,        30'h1};
    tbl[8]  = '{1, 0, 2'b10, 0, 32'h00000010, 32'h0,        TO, 0, 32'h0,       0, 32'h0,        30'h4};
    tbl[9]  = '{1, 1, 2'b10, 0, 32'h00000020, 32'h0,        0, 0, 32'h0,        0, 32'h0,        30'h0};
    tbl[10] = '{1, 0, 2'b11, 0, 32'h00000020, 32'h0,        0, 0, 32'h0,        0, 32'h0,        30'h0};

    // reset state
    #3;
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wstrb", 32'(bus_wstrb), 32'd0);
    check("rst_bus_addr", 32'(bus_addr), 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // directed table
    for (int v = 0; v < 11; v++) begin
      fw_en = tbl[v].fwe; fw = tbl[v].fwv;
      dc = done_cnt;
      run_access(tbl[v].rd, tbl[v].wr, tbl[v].w, tbl[v].sg, tbl[v].a, tbl[v].wd, tbl[v].dly);
      if (v < 9) begin
        check($sformatf("tbl%0d_first_addr", v), n_obs > 0 ? 32'(obs_addr[0]) : 32'hFFFFFFFF, 32'(tbl[v].exp_a1));
      end
      if (tbl[v].chk) begin
        check($sformatf("tbl%0d_rdata", v), rdata, tbl[v].exp_rd);
        check($sformatf("tbl%0d_done_once", v), 32'(done_cnt - dc), 32'd1);
      end else begin
        check($sformatf("tbl%0d_no_done", v), 32'(done_cnt - dc), 32'd0);
      end
    end
    fw_en = 1'b0;

    // split store: exact bus beats
    dc = done_cnt;
    run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h000001FE, 32'h11223344, 1);
    check("sw_split_beats", 32'(n_obs), 32'd2);
    check("sw_split_a1", 32'(obs_addr[0]), 32'h7F);
    check("sw_split_s1", 32'(obs_strb[0]), 32'b1100);
    check("sw_split_d1", obs_wdata[0], 32'h33440000);
    check("sw_split_a2", 32'(obs_addr[1]), 32'h80);
    check("sw_split_s2", 32'(obs_strb[1]), 32'b0011);
    check("sw_split_d2", obs_wdata[1], 32'h00001122);
    check("sw_split_done_once", 32'(done_cnt - dc), 32'd1);

    // split load across the top of the address space
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h0, 0);
    check("wrap_beats", 32'(n_obs), 32'd2);
    check("wrap_a2", 32'(obs_addr[1]), 32'h0);

    // reset in the middle of an access
    @(negedge clk);
    mem_read = 1'b1; mem_width = 2'b10; addr = 32'h00000200; bus_ack = 1'b0;
    @(negedge clk); #1;
    check("midrst_req_up", 32'(bus_req), 32'd1);
    #1;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("midrst_bus_req", 32'(bus_req), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_addr", 32'(bus_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dc = done_cnt;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("postrst_no_retry", 32'(bus_req), 32'd0);
      check("postrst_err", 32'(err), 32'd0);
    end
    check("postrst_no_done", 32'(done_cnt - dc), 32'd0);

    // randomized accesses against the byte-level model
    for (int n = 0; n < 200; n++) begin
      int r;
      logic [1:0] rw;
      r = $urandom_range(0, 15);
      rw = (r == 0) ? 2'b11 : ($urandom_range(0, 1) == 1 ? 2'b10 : 2'b01);
      run_access(rw[1], rw[0], (r == 1) ? 2'b11 : 2'($urandom_range(0, 2)), 1'($urandom),
                 $urandom, $urandom, (r == 2) ? TO + 3 : $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, 255: maximum cycles bus_req may wait for bus_ack before abort (range 1..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 mem_read  in  1  MEM-stage load request, level, held while stall=1.
REQ-005 mem_write  in  1  MEM-stage store request, level, held while stall=1.
REQ-006 mem_width  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-007 mem_sign_extend  in  1  1 = sign-extend load result, 0 = zero-extend.
REQ-008 addr  in  32  byte address; wdata  in  32  store data, low-aligned.
REQ-009 stall  out  1  holds pipeline; rdata  out  32  extended load data; done  out  1  access-complete pulse; err  out  1  error pulse.
REQ-010 bus_req  out  1; bus_we  out  1; bus_addr  out  30  word address; bus_wstrb  out  4; bus_wdata  out  32.
REQ-011 bus_ack  in  1  one-cycle accept/complete; bus_rdata  in  32  valid when bus_ack=1.

Function
REQ-012 FSM states: IDLE, REQ1, REQ2, DONE; one access in flight at most.
REQ-013 IDLE with exactly one of mem_read/mem_write=1 and mem_width!=11: capture addr, wdata, width, sign, direction; stall=1 combinationally that cycle; next state REQ1.
REQ-014 IDLE with mem_read=mem_write=1 or mem_width=11 (when either asserted): no bus access, err=1 and stall=0 for one cycle, stay IDLE.
REQ-015 Access size = 1/2/4 bytes; offset = addr[1:0]; access splits when offset+size>4.
REQ-016 REQ1: bus_req=1, bus_addr=addr[31:2], strobes = lanes offset..min(3,offset+size-1), bus_wdata = wdata shifted left 8*offset bits.
REQ-017 REQ2: bus_addr = addr[31:2]+1 (wraps 3FFFFFFF -> 0), strobes = lanes 0..offset+size-5, bus_wdata = wdata shifted right 8*(4-offset) bits.
REQ-018 bus_wstrb = 0000 when bus_we=0; bus_we = captured direction in REQ1/REQ2.
REQ-019 bus_req, bus_addr, bus_we, bus_wstrb, bus_wdata registered and stable from assertion until the cycle bus_ack=1; bus_req drops the following cycle unless REQ2 follows.
REQ-020 bus_ack in REQ1: split -> REQ2, else -> DONE; bus_ack in REQ2 -> DONE; bus_ack outside REQ1/REQ2 ignored.
REQ-021 Load bytes from REQ1/REQ2 assembled into a registered buffer; DONE: rdata = bytes [size-1:0] extended to 32 per mem_sign_extend; rdata = 0 on stores.
REQ-022 DONE: stall=0, done=1 one cycle, rdata valid; next state IDLE unconditionally.
REQ-023 stall=1 in REQ1 and REQ2 regardless of inputs; input changes while stall=1 ignored (captured copy used).
REQ-024 Wait counter (8 bit) clears on entry to REQ1/REQ2, increments each cycle without bus_ack; reaching TIMEOUT_CYC: bus_req drops, err=1, stall=0 one cycle, -> IDLE, no done.
REQ-025 Minimum latency: aligned access with immediate ack = request cycle + REQ1 + DONE = stall 2 cycles; split adds 1.
REQ-026 rdata holds last value outside DONE.

Reset
REQ-027 rst_n=0 asynchronously forces IDLE; bus_req, bus_we, stall, done, err = 0; bus_wstrb = 0000; bus_addr, bus_wdata, rdata, counter, buffers = 0.
REQ-028 Reset mid-access abandons it; no done/err; bus_req low within the reset assertion, no retry after release.

Structure
REQ-029 Shared package holds state encoding, width codes (BYTE/HALF/WORD/RSVD) and lane-mask constants.
REQ-030 One combinational sub-module mem_load_align: lane extraction plus sign/zero extension for rdata.

Verification
REQ-031 Aligned lw addr=0x100, ack 1 cycle after bus_req, bus_rdata=0xDEADBEEF -> bus_addr=0x40, wstrb 0000, done with rdata=0xDEADBEEF, stall 2 cycles.
REQ-032 lb sign addr=0x103, bus_rdata=0x80xxxxxx -> rdata=0xFFFFFF80; same with sign_extend=0 -> 0x00000080.
REQ-033 Split sw addr=0x1FE wdata=0x11223344 -> REQ1 addr 0x7F wstrb 1100 wdata 0x33440000; REQ2 addr 0x80 wstrb 0011 wdata 0x00001122; done once.
REQ-034 Split lw addr=0xFFFFFFFF -> second bus_addr wraps to 0x0; assembled rdata correct.
REQ-035 No ack for TIMEOUT_CYC=4 cycles -> err pulse, bus_req low, stall low, FSM IDLE, no done.
REQ-036 mem_read=mem_write=1 -> err pulse, bus_req stays 0; rst_n low during REQ1 -> bus_req 0 immediately, IDLE after release.
